// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch -- instruction fetch unit with a small prefetch queue.
//
// Fetches sequential 32-bit words from an instruction ROM whose data is
// available combinationally in the same cycle as the address. Each fetched
// {pc, inst} pair is pushed into a DEPTH-entry circular queue that decode
// drains through a valid/ready handshake. A redirect from the core flushes
// the queue and restarts fetching at the word-aligned target.
//
// Parameters
//   DEPTH     number of queue entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous reset, active low
//   rom_ce_o       ROM chip enable; high when a word is pushed this cycle
//   rom_addr_o     ROM byte address (always the current fetch PC)
//   rom_data_i     ROM word for rom_addr_o, same cycle
//   redirect_i     flush the queue and reload the fetch PC
//   redirect_pc_i  redirect target (low two bits ignored)
//   if_valid_o     head entry valid toward decode
//   if_ready_i     decode accepts the head entry
//   if_pc_o        PC of the head entry (0 when empty)
//   if_inst_o      instruction of the head entry (0 when empty)
//   count_o        current queue occupancy
// -----------------------------------------------------------------------------
module if_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     rom_ce_o,
   output logic [31:0]              rom_addr_o,
   input  logic [31:0]              rom_data_i,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   output logic                     if_valid_o,
   input  logic                     if_ready_i,
   output logic [31:0]              if_pc_o,
   output logic [31:0]              if_inst_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [PW:0]   count_q,    count_d;

   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_inst [DEPTH];

   logic push;
   logic pop;

   // The two low bits of the redirect target are dropped by design; this
   // keeps them visibly consumed.
   logic [1:0] unused_redirect_lsb;
   assign unused_redirect_lsb = redirect_pc_i[1:0];

   // A redirect cancels both push and pop in its cycle. Fullness is judged on
   // the registered count, so a pop while full never frees a slot for a push
   // in that same cycle.
   assign push = rst && !redirect_i && (count_q != FULL_CNT);
   assign pop  = !redirect_i && (count_q != '0) && if_ready_i;

   assign rom_ce_o   = push;
   assign rom_addr_o = fetch_pc_q;
   assign if_valid_o = (count_q != '0);
   assign count_o    = count_q;

   always_comb begin
      if_pc_o   = '0;
      if_inst_o = '0;
      if (count_q != '0) begin
         if_pc_o   = mem_pc[rd_ptr_q];
         if_inst_o = mem_inst[rd_ptr_q];
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (redirect_i) begin
         fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         // Pointers are exactly PW bits wide, so they wrap modulo DEPTH for
         // free; fetch_pc wraps modulo 2^32 the same way.
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: queue storage has no reset; an entry is only ever read after it
   // has been written, because the outputs are forced to 0 while count is 0.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]   <= fetch_pc_q;
         mem_inst[wr_ptr_q] <= rom_data_i;
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch -- self-checking bench for if_prefetch.
//
// The reference model is a queue of {pc, inst} entries plus a fetch PC,
// advanced once per clock from the behavioural rules of the prefetcher.
// Directed sequences cover fill, streaming, redirect, wrap, full-with-pop,
// held redirect and asynchronous reset; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_if_prefetch;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic        clk;
   logic        rst_n;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_valid_o;
   logic        if_ready_i;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic [2:0]  count_o;

   int tests;
   int fails;

   entry_t      m_q[$];
   logic [31:0] m_pc;

   if_prefetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst_n),
      .rom_ce_o      (rom_ce_o),
      .rom_addr_o    (rom_addr_o),
      .rom_data_i    (rom_data_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .if_valid_o    (if_valid_o),
      .if_ready_i    (if_ready_i),
      .if_pc_o       (if_pc_o),
      .if_inst_o     (if_inst_o),
      .count_o       (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a + 32'h1000;
   endfunction

   // ROM responds combinationally to the address.
   assign rom_data_i = rom_word(rom_addr_o);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic exp_ce;
      exp_ce = rst_n && !redirect_i && (m_q.size() < DEPTH);
      check("rom_ce",   32'(rom_ce_o),   32'(exp_ce));
      check("rom_addr", rom_addr_o,      m_pc);
      check("if_valid", 32'(if_valid_o), 32'(m_q.size() != 0));
      check("if_pc",    if_pc_o,         (m_q.size() != 0) ? m_q[0].pc   : 32'h0);
      check("if_inst",  if_inst_o,       (m_q.size() != 0) ? m_q[0].inst : 32'h0);
      check("count",    32'(count_o),    32'(m_q.size()));
   endtask

   // Entered and left at a falling edge: drive inputs, check, clock the model.
   task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
      logic   do_push;
      logic   do_pop;
      entry_t tmp;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      if_ready_i    = rdy;
      #1;
      check_outputs();
      do_push = rst_n && !rd && (m_q.size() < DEPTH);
      do_pop  = rst_n && !rd && rdy && (m_q.size() != 0);
      @(posedge clk);
      if (rst_n) begin
         if (rd) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
         end else begin
            if (do_pop) tmp = m_q.pop_front();
            if (do_push) begin
               m_q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      rst_n         = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      if_ready_i    = 1'b0;
      m_pc          = RESET_PC;

      // Reset state.
      #2;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // First cycle after release fetches RESET_PC.
      #1;
      check("first_ce",   32'(rom_ce_o), 32'h1);
      check("first_addr", rom_addr_o,    RESET_PC);

      // Sequential fill with decode stalled.
      repeat (5) step(1'b0, 32'h0, 1'b0);
      check("fill_count", 32'(count_o), 32'd4);
      check("fill_addr",  rom_addr_o,   32'h10);
      check("fill_ce",    32'(rom_ce_o), 32'h0);

      // Full with pop: no push this edge, push resumes next edge.
      step(1'b0, 32'h0, 1'b1);
      check("fullpop_count", 32'(count_o), 32'd3);
      check("fullpop_addr",  rom_addr_o,   32'h10);
      step(1'b0, 32'h0, 1'b0);
      check("resume_count", 32'(count_o), 32'd4);
      check("resume_addr",  rom_addr_o,   32'h14);

      // Redirect while full, target with low bits set.
      step(1'b1, 32'h0000_0103, 1'b0);
      check("redir_count", 32'(count_o), 32'd0);
      check("redir_addr",  rom_addr_o,   32'h100);
      step(1'b0, 32'h0, 1'b0);
      check("redir_pc",    if_pc_o,      32'h100);

      // Streaming from 0: one instruction per cycle, occupancy 1.
      step(1'b1, 32'h0, 1'b1);
      repeat (10) step(1'b0, 32'h0, 1'b1);
      check("stream_count", 32'(count_o), 32'd1);

      // Address wrap past 2^32.
      step(1'b1, 32'hFFFF_FFF8, 1'b0);
      repeat (3) step(1'b0, 32'h0, 1'b0);
      check("wrap_head", if_pc_o, 32'hFFFF_FFF8);
      repeat (4) step(1'b0, 32'h0, 1'b1);

      // Redirect held for several cycles; the last target wins.
      step(1'b1, 32'h0000_0400, 1'b1);
      step(1'b1, 32'h0000_0800, 1'b1);
      step(1'b1, 32'h0000_0C07, 1'b1);
      check("held_addr", rom_addr_o, 32'h0C04);
      repeat (3) step(1'b0, 32'h0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) == 0), $urandom, 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset with three entries queued.
      step(1'b1, 32'h0000_0200, 1'b0);
      repeat (3) step(1'b0, 32'h0, 1'b0);
      check("pre_rst_count", 32'(count_o), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(if_valid_o), 32'h0);
      check("async_count", 32'(count_o),    32'd0);
      m_q.delete();
      m_pc = RESET_PC;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) step(1'b0, 32'h0, 1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of instruction-queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port rom_ce_o  output  1  instruction ROM chip enable.
REQ-006 The module SHALL have port rom_addr_o  output  32  instruction ROM byte address.
REQ-007 The module SHALL have port rom_data_i  input  32  ROM instruction, valid combinationally in the same cycle as rom_addr_o.
REQ-008 The module SHALL have port redirect_i  input  1  branch/jump redirect request from the core.
REQ-009 The module SHALL have port redirect_pc_i  input  32  redirect target address.
REQ-010 The module SHALL have port if_valid_o  output  1  head queue entry valid toward decode.
REQ-011 The module SHALL have port if_ready_i  input  1  decode accepts the head entry.
REQ-012 The module SHALL have port if_pc_o  output  32  PC of the head entry.
REQ-013 The module SHALL have port if_inst_o  output  32  instruction of the head entry.
REQ-014 The module SHALL have port count_o  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 State SHALL be: fetch_pc (32 bits), a circular queue of DEPTH {pc, inst} entries, and read pointer, write pointer and count.
REQ-016 rom_addr_o SHALL equal fetch_pc at all times.
REQ-017 rom_ce_o SHALL be 1 exactly when rst is high, count < DEPTH and redirect_i is 0.
REQ-018 Push: on a rising edge with rom_ce_o=1, {fetch_pc, rom_data_i} SHALL be written at the write pointer, the write pointer SHALL advance modulo DEPTH, and fetch_pc SHALL advance by 4.
REQ-019 fetch_pc SHALL wrap modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-020 Pop: on a rising edge with if_valid_o=1 and if_ready_i=1, the read pointer SHALL advance modulo DEPTH.
REQ-021 if_valid_o SHALL be (count != 0).
REQ-022 if_pc_o and if_inst_o SHALL show the head entry, and SHALL be 0 when count = 0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push alone SHALL add 1; pop alone SHALL subtract 1.
REQ-024 Full (count = DEPTH): no push, fetch_pc held; a pop in the full cycle SHALL NOT enable a push in that same cycle.
REQ-025 Empty (count = 0): if_valid_o = 0, and if_ready_i SHALL be ignored.
REQ-026 Redirect: on a rising edge with redirect_i=1, the queue SHALL be flushed (count and both pointers set to 0), fetch_pc SHALL load {redirect_pc_i[31:2], 2'b00}, and any push or pop in that cycle SHALL be discarded.
REQ-027 After a redirect, the first push SHALL occur on the next rising edge at the new fetch_pc, giving a minimum redirect-to-if_valid_o latency of 2 edges.
REQ-028 A redirect held for N consecutive cycles SHALL reload fetch_pc on every edge, and the last redirect_pc_i value SHALL win.
REQ-029 Instruction data SHALL be stored unmodified, with no decode and no alignment checks on rom_data_i.
REQ-030 count_o SHALL equal count.

Reset
REQ-031 While rst=0, asynchronously: fetch_pc=RESET_PC, count=0, pointers=0, queue contents don't-care.
REQ-032 During reset the outputs SHALL be rom_ce_o=0, rom_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=0, count_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock.
REQ-034 On the first cycle after reset release, rom_ce_o SHALL be 1 with rom_addr_o=RESET_PC.

Verification
REQ-035 Sequential fill: ROM word at address A = A+32'h1000, if_ready_i=0 -> four pushes (PCs 0,4,8,C), count_o=4, rom_ce_o=0, rom_addr_o=32'h10 held.
REQ-036 Streaming: if_ready_i=1 throughout -> steady state of one instruction per cycle, if_pc_o sequence 0,4,8,..., count_o stays at 1.
REQ-037 Redirect while full: redirect_i=1, redirect_pc_i=32'h0000_0103 -> next cycle count_o=0, rom_addr_o=32'h100; following cycle if_pc_o=32'h100.
REQ-038 Wrap: redirect to 32'hFFFF_FFF8 -> entries at FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-039 Full with pop: count_o=4 and if_ready_i=1 -> count_o becomes 3, no push that edge; the push resumes on the next edge.
REQ-040 Asynchronous reset: rst driven low between clock edges with count_o=3 -> if_valid_o=0 and count_o=0 immediately; after release, fetching restarts at RESET_PC.
